lc3_sequencer: RTL

LC3_SEQUENCER -- requirements
Module: lc3_sequencer

---
 rtl/lc3_pkg.sv | 64 ++++++
 rtl/lc3_sequencer_if.sv | 36 +++
 rtl/lc3_wait_ctr.sv | 25 ++
 rtl/lc3_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 control sequencer: state encoding, opcode
// constants, datapath mux/ALU encodings and the packed control word.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH, S_MEM_RD, S_MEM_WR, S_LOAD_IR, S_PAUSE, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP, S_JSR_LINK, S_JSR_OFF,
    S_JSRR, S_LDR_ADDR, S_STR_ADDR, S_STR_DATA, S_LDI_ADDR, S_LDI_PTR,
    S_LD_WB, S_LEA
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] BUS_PC     = 2'b00;
  localparam logic [1:0] BUS_MDR    = 2'b01;
  localparam logic [1:0] BUS_ALU    = 2'b10;
  localparam logic [1:0] BUS_MARMUX = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  localparam logic [1:0] A2_OFF11 = 2'b00;
  localparam logic [1:0] A2_OFF9  = 2'b01;
  localparam logic [1:0] A2_OFF6  = 2'b10;
  localparam logic [1:0] A2_ZERO  = 2'b11;

  localparam logic [1:0] PCM_INC  = 2'b00;
  localparam logic [1:0] PCM_BUS  = 2'b01;
  localparam logic [1:0] PCM_ADDR = 2'b10;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic [1:0] bus_mux;
    logic [1:0] pc_mux;
    logic [1:0] dr_mux;
    logic [1:0] sr1_mux;
    logic       addr1_mux;
    logic [1:0] addr2_mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctl_t;

  // Idle control word: no strobes, SRAM strobes (active-low) released.
  localparam ctl_t CTL_IDLE = '{mem_oe: 1'b1, mem_we: 1'b1, default: '0};

endpackage

// File: rtl/lc3_sequencer_if.sv
// Control bus between the sequencer and the LC-3 datapath.
// Handshake: Run is sampled only in HALTED (1 = start); Continue is an
// active-low level sampled only in PAUSE (0 = resume). Neither is latched,
// so the driver must hold it until the sequencer has left that state.
interface lc3_sequencer_if;
  import lc3_pkg::*;

  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_11;
  logic       branch_enable;

  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic [1:0] busMux, PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
  logic       ADDR1MUX;
  logic       Mem_OE, Mem_WE;
  logic       Illegal;
  state_e     state_dbg;

  // Sequencer side.
  modport master (
    input  Run, Continue, Opcode, IR_11, branch_enable,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
           busMux, PCMUX, DRMUX, SR1MUX, ADDR1MUX, ADDR2MUX, ALUK,
           Mem_OE, Mem_WE, Illegal, state_dbg
  );

  // Datapath / environment side.
  modport slave (
    output Run, Continue, Opcode, IR_11, branch_enable,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
           busMux, PCMUX, DRMUX, SR1MUX, ADDR1MUX, ADDR2MUX, ALUK,
           Mem_OE, Mem_WE, Illegal, state_dbg
  );
endinterface

// File: rtl/lc3_wait_ctr.sv
// Memory access wait counter: loads the cycle budget on access entry and
// counts down to zero; done marks the final cycle of the access.
module lc3_wait_ctr (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       done
);
  logic [2:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign done = (count == 3'd0);
endmodule

// File: rtl/lc3_sequencer.sv
// LC-3 multi-cycle control sequencer. Outputs are decoded from the
// registered state (plus the wait counter in MEM_RD), so they are Moore.
module lc3_sequencer
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int PAUSE_EN = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  lc3_sequencer_if.master bus
);
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_e state, nxt, ret_state;
  logic   illegal_q, op_illegal;
  logic   ctr_load, ctr_done;
  ctl_t   ctl;

  // A memory state is entered from elsewhere: restart the wait count.
  assign ctr_load = (nxt == S_MEM_RD || nxt == S_MEM_WR) && (state != nxt);

  lc3_wait_ctr u_wait_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (ctr_load),
    .load_val (WAIT_INIT),
    .dec      (state == S_MEM_RD || state == S_MEM_WR),
    .done     (ctr_done)
  );

  // Next-state selection and opcode dispatch.
  always_comb begin
    nxt        = state;
    op_illegal = 1'b0;
    case (state)
      S_HALTED:   if (bus.Run) nxt = S_FETCH;
      S_FETCH:    nxt = S_MEM_RD;
      S_MEM_RD:   if (ctr_done) nxt = ret_state;
      S_MEM_WR:   if (ctr_done) nxt = S_FETCH;
      S_LOAD_IR:  nxt = (PAUSE_EN != 0) ? S_PAUSE : S_DECODE;
      S_PAUSE:    if (!bus.Continue) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_ADD:  nxt = S_ADD;
          OP_AND:  nxt = S_AND;
          OP_NOT:  nxt = S_NOT;
          OP_BR:   nxt = S_BR;
          OP_JMP:  nxt = S_JMP;
          OP_JSR:  nxt = S_JSR_LINK;
          OP_LDR:  nxt = S_LDR_ADDR;
          OP_STR:  nxt = S_STR_ADDR;
          OP_LDI:  nxt = S_LDI_ADDR;
          OP_LEA:  nxt = S_LEA;
          default: begin
            nxt        = S_FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      S_BR:       nxt = bus.branch_enable ? S_BR_TAKE : S_FETCH;
      S_JSR_LINK: nxt = bus.IR_11 ? S_JSR_OFF : S_JSRR;
      S_LDR_ADDR, S_LDI_ADDR, S_LDI_PTR: nxt = S_MEM_RD;
      S_STR_ADDR: nxt = S_STR_DATA;
      S_STR_DATA: nxt = S_MEM_WR;
      default:    nxt = S_FETCH;
    endcase
  end

  // State, read-return target and sticky illegal flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_HALTED;
      ret_state <= S_LOAD_IR;
      illegal_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == S_MEM_RD && state != S_MEM_RD) begin
        case (state)
          S_FETCH:    ret_state <= S_LOAD_IR;
          S_LDI_ADDR: ret_state <= S_LDI_PTR;
          default:    ret_state <= S_LD_WB;
        endcase
      end
      if (op_illegal && state == S_DECODE) illegal_q <= 1'b1;
    end
  end

  // Control word decode from the current state.
  always_comb begin
    ctl = CTL_IDLE;
    case (state)
      S_FETCH:   begin ctl.bus_mux = BUS_PC; ctl.ld_mar = 1'b1; ctl.ld_pc = 1'b1; ctl.pc_mux = PCM_INC; end
      S_MEM_RD:  begin ctl.mem_oe = 1'b0; ctl.ld_mdr = ctr_done; end
      S_MEM_WR:  ctl.mem_we = 1'b0;
      S_LOAD_IR: begin ctl.bus_mux = BUS_MDR; ctl.ld_ir = 1'b1; end
      S_DECODE:  ctl.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ctl.aluk    = (state == S_ADD) ? ALU_ADD : (state == S_AND) ? ALU_AND : ALU_NOT;
        ctl.bus_mux = BUS_ALU; ctl.ld_reg = 1'b1; ctl.ld_cc = 1'b1;
      end
      S_BR_TAKE: begin ctl.addr1_mux = 1'b0; ctl.addr2_mux = A2_OFF9; ctl.pc_mux = PCM_ADDR; ctl.ld_pc = 1'b1; end
      S_JMP, S_JSRR: begin ctl.aluk = ALU_PASSA; ctl.bus_mux = BUS_ALU; ctl.pc_mux = PCM_BUS; ctl.ld_pc = 1'b1; end
      S_JSR_LINK: begin ctl.bus_mux = BUS_PC; ctl.dr_mux = 2'b01; ctl.ld_reg = 1'b1; end
      S_JSR_OFF: begin ctl.addr2_mux = A2_OFF11; ctl.pc_mux = PCM_ADDR; ctl.ld_pc = 1'b1; end
      S_LDR_ADDR, S_STR_ADDR: begin
        ctl.addr1_mux = 1'b1; ctl.addr2_mux = A2_OFF6; ctl.bus_mux = BUS_MARMUX; ctl.ld_mar = 1'b1;
      end
      S_STR_DATA: begin ctl.sr1_mux = 2'b01; ctl.aluk = ALU_PASSA; ctl.bus_mux = BUS_ALU; ctl.ld_mdr = 1'b1; end
      S_LDI_ADDR: begin ctl.addr2_mux = A2_OFF9; ctl.bus_mux = BUS_MARMUX; ctl.ld_mar = 1'b1; end
      S_LDI_PTR: begin ctl.bus_mux = BUS_MDR; ctl.ld_mar = 1'b1; end
      S_LD_WB:   begin ctl.bus_mux = BUS_MDR; ctl.ld_reg = 1'b1; ctl.ld_cc = 1'b1; end
      S_LEA:     begin ctl.addr2_mux = A2_OFF9; ctl.bus_mux = BUS_MARMUX; ctl.ld_reg = 1'b1; ctl.ld_cc = 1'b1; end
      default:   ctl = CTL_IDLE;
    endcase
  end

  assign bus.LD_MAR    = ctl.ld_mar;
  assign bus.LD_MDR    = ctl.ld_mdr;
  assign bus.LD_IR     = ctl.ld_ir;
  assign bus.LD_BEN    = ctl.ld_ben;
  assign bus.LD_CC     = ctl.ld_cc;
  assign bus.LD_REG    = ctl.ld_reg;
  assign bus.LD_PC     = ctl.ld_pc;
  assign bus.busMux    = ctl.bus_mux;
  assign bus.PCMUX     = ctl.pc_mux;
  assign bus.DRMUX     = ctl.dr_mux;
  assign bus.SR1MUX    = ctl.sr1_mux;
  assign bus.ADDR1MUX  = ctl.addr1_mux;
  assign bus.ADDR2MUX  = ctl.addr2_mux;
  assign bus.ALUK      = ctl.aluk;
  assign bus.Mem_OE    = ctl.mem_oe;
  assign bus.Mem_WE    = ctl.mem_we;
  assign bus.Illegal   = illegal_q;
  assign bus.state_dbg = state;
endmodule
